// File: rtl/tone_sequencer.sv
// Melody/keyboard tone scheduler: fetches {dur,tone} entries from an external ROM,
// times notes with a trailing silent gap, and lets held live keys override and pause playback.
module tone_sequencer #(
   parameter int BEAT_DIV   = 12_500_000,
   parameter int GAP_CYCLES = 1_000_000,
   parameter int SONG_LEN   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [20:0] keys,
   input  logic        play_start,
   input  logic        play_stop,
   input  logic        loop_en,
   output logic [4:0]  rom_addr,
   input  logic [8:0]  rom_data,
   output logic [4:0]  tone_out,
   output logic        busy,
   output logic        live
);

   localparam int TW = $clog2(15 * BEAT_DIV + 1);
   localparam logic [TW-1:0] BEAT_W    = TW'(BEAT_DIV);
   localparam logic [TW-1:0] GAP_W     = TW'(GAP_CYCLES);
   localparam logic [TW-1:0] TIMER_ONE = TW'(1);
   localparam logic [4:0]    LAST_ADDR = 5'(SONG_LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_NOTE, S_GAP} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [4:0]    addr_nxt;
   logic [4:0]    tone_cap, tone_cap_nxt;
   logic [4:0]    tone_d;
   logic          live_d;
   logic [4:0]    live_tone;
   logic          any_key;
   logic [3:0]    dur;

   assign dur     = rom_data[8:5];
   assign any_key = |keys;

   // Lowest pressed key has priority: scan from the top so the lowest index is written last.
   always_comb begin
      live_tone = '0;
      for (int i = 20; i >= 0; i--)
         if (keys[i]) live_tone = 5'(i + 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rom_addr <= '0;
         timer    <= '0;
         tone_cap <= '0;
         tone_out <= '0;
         live     <= 1'b0;
      end else begin
         state    <= state_nxt;
         rom_addr <= addr_nxt;
         timer    <= timer_nxt;
         tone_cap <= tone_cap_nxt;
         tone_out <= tone_d;
         live     <= live_d;
      end
   end

   always_comb begin
      state_nxt    = state;
      addr_nxt     = rom_addr;
      timer_nxt    = timer;
      tone_cap_nxt = tone_cap;
      if (play_stop) begin
         state_nxt = S_IDLE;
         addr_nxt  = '0;
         timer_nxt = '0;
      end else if (play_start) begin
         state_nxt = S_FETCH;
         addr_nxt  = '0;
      end else begin
         case (state)
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
               if (dur == 4'd0) begin
                  state_nxt = loop_en ? S_FETCH : S_IDLE;
                  addr_nxt  = '0;
               end else begin
                  // The gap is carved out of the note so each entry spans dur*BEAT_DIV cycles.
                  tone_cap_nxt = rom_data[4:0];
                  timer_nxt    = TW'(dur) * BEAT_W - GAP_W;
                  state_nxt    = S_NOTE;
               end
            end
            S_NOTE: begin
               if (!any_key) begin
                  if (timer == TIMER_ONE) begin
                     timer_nxt = GAP_W;
                     state_nxt = S_GAP;
                  end else begin
                     timer_nxt = timer - TIMER_ONE;
                  end
               end
            end
            S_GAP: begin
               if (!any_key) begin
                  if (timer == TIMER_ONE) begin
                     timer_nxt = '0;
                     if (rom_addr == LAST_ADDR) begin
                        state_nxt = loop_en ? S_FETCH : S_IDLE;
                        addr_nxt  = '0;
                     end else begin
                        state_nxt = S_FETCH;
                        addr_nxt  = rom_addr + 5'd1;
                     end
                  end else begin
                     timer_nxt = timer - TIMER_ONE;
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state != S_IDLE);
      live_d = any_key;
      tone_d = '0;
      if (any_key)
         tone_d = live_tone;
      else if (state == S_NOTE)
         tone_d = tone_cap;
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus random keys/ROM/start/stop, checked
// each cycle against a segment-queue model of the expected playback timeline.
module tb_tone_sequencer;
   localparam int BD = 10;
   localparam int GP = 2;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [20:0] keys = '0;
   logic        play_start = 1'b0;
   logic        play_stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [4:0]  rom_addr;
   logic [8:0]  rom_data = '0;
   logic [4:0]  tone_out;
   logic        busy;
   logic        live;
   logic [8:0]  rom [0:SL-1];

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

   tone_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GP), .SONG_LEN(SL)) dut (
      .clk(clk), .rst_n(rst_n), .keys(keys), .play_start(play_start), .play_stop(play_stop),
      .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data), .tone_out(tone_out),
      .busy(busy), .live(live)
   );

   // Playback timeline: kind 0 fetch, 1 load, 2 note, 3 gap; notes and gaps pause under keys.
   typedef struct {int kind; int tone; int len; int addr;} seg_t;
   seg_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_tone = 0;
   int   exp_live = 0;
   int   hist [0:31];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [20:0] k);
      for (int i = 0; i < 21; i++) if (k[i]) return i + 1;
      return 0;
   endfunction

   function automatic void build();
      for (int i = 0; i < SL; i++) begin
         int d;
         d = int'(rom[i][8:5]);
         q.push_back('{0, 0, 1, i});
         q.push_back('{1, 0, 1, i});
         if (d == 0) break;
         q.push_back('{2, int'(rom[i][4:0]), d * BD - GP, i});
         q.push_back('{3, 0, GP, i});
      end
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < 32; i++) hist[i] = 0;
   endtask

   task automatic cycle(input logic [20:0] k, input bit st, input bit sp);
      seg_t s;
      chk("tone_out", 32'(tone_out), exp_tone);
      chk("live", 32'(live), exp_live);
      chk("busy", 32'(busy), (q.size() != 0) ? 1 : 0);
      chk("rom_addr", 32'(rom_addr), (q.size() != 0) ? q[0].addr : 0);
      if (!$isunknown(tone_out)) hist[tone_out]++;
      keys = k; play_start = st; play_stop = sp;
      if (k != 0) begin
         exp_live = 1; exp_tone = lowest(k);
      end else begin
         exp_live = 0; exp_tone = (q.size() != 0) ? q[0].tone : 0;
      end
      if (sp) q.delete();
      else if (st) begin q.delete(); build(); end
      else if (q.size() != 0 && !(k != 0 && q[0].kind >= 2)) begin
         s = q[0];
         s.len--;
         if (s.len == 0) begin
            void'(q.pop_front());
            if (q.size() == 0 && loop_en) build();
         end else q[0] = s;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle('0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [20:0] k;
      int nz;
      clear_hist();
      for (int i = 0; i < SL; i++) rom[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tone_out", 32'(tone_out), 0);
      chk("rst_live", 32'(live), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      rst_n = 1'b1;
      idle(2);

      // Two notes then terminator
      rom[0] = {4'd1, 5'd5}; rom[1] = {4'd2, 5'd8}; rom[2] = {4'd0, 5'd3}; rom[3] = {4'd1, 5'd9};
      clear_hist();
      cycle('0, 1'b1, 1'b0);
      idle(45);
      chk("t1_tone5_cycles", hist[5], 8);
      chk("t1_tone8_cycles", hist[8], 18);

      // Full ROM, no terminator, without and with looping
      rom[0] = {4'd1, 5'd1}; rom[1] = {4'd1, 5'd2}; rom[2] = {4'd1, 5'd3}; rom[3] = {4'd1, 5'd4};
      cycle('0, 1'b1, 1'b0);
      idle(55);
      loop_en = 1'b1;
      cycle('0, 1'b1, 1'b0);
      idle(70);
      cycle('0, 1'b0, 1'b1);
      loop_en = 1'b0;
      idle(2);

      // Live override pauses a dur-1 note
      rom[0] = {4'd1, 5'd5}; rom[1] = {4'd0, 5'd0};
      clear_hist();
      cycle('0, 1'b1, 1'b0);
      idle(4);
      repeat (5) cycle(21'h000084, 1'b0, 1'b0);
      idle(20);
      chk("t3_tone5_cycles", hist[5], 8);
      chk("t3_tone3_cycles", hist[3], 5);

      // Start+stop together mid-note, then restart mid-song
      rom[0] = {4'd1, 5'd6}; rom[1] = {4'd2, 5'd7}; rom[2] = {4'd0, 5'd0};
      cycle('0, 1'b1, 1'b0);
      idle(6);
      cycle('0, 1'b1, 1'b1);
      idle(4);
      cycle('0, 1'b1, 1'b0);
      idle(17);
      cycle('0, 1'b1, 1'b0);
      idle(40);

      // Rest entry
      rom[0] = {4'd2, 5'd0}; rom[1] = {4'd0, 5'd0};
      clear_hist();
      cycle('0, 1'b1, 1'b0);
      idle(28);
      nz = 0;
      for (int i = 1; i < 32; i++) nz += hist[i];
      chk("t5_rest_nonzero_cycles", nz, 0);

      // Asynchronous reset mid-gap with a key held
      rom[0] = {4'd1, 5'd5}; rom[1] = {4'd0, 5'd0};
      cycle('0, 1'b1, 1'b0);
      for (int n = 0; n < 40 && !(q.size() != 0 && q[0].kind == 3); n++) cycle('0, 1'b0, 1'b0);
      chk("t6_gap_reached", (q.size() != 0 && q[0].kind == 3) ? 1 : 0, 1);
      cycle(21'h000004, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_tone_out", 32'(tone_out), 0);
      chk("t6_async_live", 32'(live), 0);
      chk("t6_async_busy", 32'(busy), 0);
      chk("t6_async_rom_addr", 32'(rom_addr), 0);
      q.delete(); exp_tone = 0; exp_live = 0;
      @(posedge clk); #1;
      chk("t6_held_tone_out", 32'(tone_out), 0);
      chk("t6_held_live", 32'(live), 0);
      rst_n = 1'b1;
      cycle(21'h000004, 1'b0, 1'b0);
      idle(4);

      // Random ROM, keys, loop, start/stop
      k = '0;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < SL; i++) rom[i] = {4'($urandom_range(0, 3)), 5'($urandom_range(0, 21))};
         loop_en = 1'($urandom_range(0, 1));
         cycle('0, 1'b1, 1'b0);
         for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 5) == 0)
               k = ($urandom_range(0, 2) != 0) ? '0 :
                   ($urandom_range(0, 1) == 0) ? 21'($urandom) : (21'd1 << $urandom_range(0, 20));
            cycle(k, $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
         end
         k = '0;
         cycle('0, 1'b0, 1'b1);
         loop_en = 1'b0;
         idle(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Note scheduler that drives the 5-bit tone command of the audio tone generator. It arbitrates between the live 21-key keyboard and an auto-play melody stored in an external note ROM. It fetches and times melody entries, inserts articulation gaps, and pauses playback while any live key is held. It sits between the key/button front end and the tone generator; `tone_out` connects directly to the generator's `tone` input (0 = silence, 1..21 = notes).

## Interface
- `BEAT_DIV`, 12_500_000: clk cycles per duration unit (125 ms at 100 MHz).
- `GAP_CYCLES`, 1_000_000: silent cycles at the end of every note. Must satisfy 0 < `GAP_CYCLES` < `BEAT_DIV`.
- `SONG_LEN`, 32: number of ROM entries (addresses 0..SONG_LEN-1), ≤ 32.
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `keys` in 21: live keys, already debounced and synchronous; bit i pressed selects tone i+1.
- `play_start` in 1: one-cycle pulse that starts or restarts the melody at address 0.
- `play_stop` in 1: one-cycle pulse that aborts the melody.
- `loop_en` in 1: level; when 1, restart at address 0 after the end of the song.
- `rom_addr` out 5: note ROM address.
- `rom_data` in 9: {dur[3:0], tone[4:0]}, valid exactly 1 cycle after `rom_addr` changes. dur = 0 marks end of song. tone = 0 is a rest.
- `tone_out` out 5: registered tone command to the generator.
- `busy` out 1: 1 in every state except IDLE.
- `live` out 1: registered; 1 when `tone_out` currently comes from `keys`.

## Operation
- States:
  - IDLE: no melody activity.
  - FETCH: `rom_addr` is stable; wait one cycle for ROM data.
  - LOAD: capture `rom_data` and decode it.
  - NOTE: play the captured tone.
  - GAP: output silence between notes.
- IDLE → FETCH on `play_start`; `rom_addr` is set to 0.
- FETCH → LOAD after exactly 1 cycle.
- LOAD:
  - dur = 0 → end of song.
  - otherwise capture tone and dur, load the timer with dur*BEAT_DIV − GAP_CYCLES, then go to NOTE.
- NOTE: the timer decrements once per cycle. When it reaches 1, load the timer with GAP_CYCLES and go to GAP.
- GAP: the melody tone is 0. When the timer reaches 1:
  - if `rom_addr` = SONG_LEN−1 → end of song;
  - otherwise increment `rom_addr` and go to FETCH.
- End of song:
  - `loop_en` = 1 → set `rom_addr` to 0, go to FETCH.
  - `loop_en` = 0 → go to IDLE.
- Total cycles per entry from entering NOTE to leaving GAP = dur*BEAT_DIV exactly. Fetch and load add 2 cycles per entry.
- Timer width is clog2(15*BEAT_DIV+1) bits. The product dur*BEAT_DIV is computed at that width with no truncation.
- Live arbitration:
  - The lowest set bit of `keys` wins, giving live tone = index+1.
  - Any key pressed → `tone_out` = live tone and `live` = 1, in every state.
  - While any key is pressed in NOTE or GAP, the timer is frozen and state does not advance. Playback resumes with the remaining count on release.
  - FETCH and LOAD are not frozen.
- No key pressed → `tone_out` = captured tone in NOTE, and 0 in IDLE, FETCH, LOAD and GAP.
- `play_stop` in any state → IDLE, `rom_addr` = 0, timer cleared.
- `play_start` and `play_stop` in the same cycle → stop wins.
- `play_start` while `busy` → restart: `rom_addr` = 0, FETCH.
- Reset (asynchronous, any time including mid-note) → IDLE. All outputs: `rom_addr` = 0, `tone_out` = 0, `busy` = 0, `live` = 0, timer = 0.

## Timing
- `tone_out` and `live` are registered and reflect `keys` and state with 1 cycle of latency.
- `play_start` at cycle 0:
  - FETCH at cycle 1 (`rom_addr` = 0, `busy` = 1);
  - LOAD at cycle 2;
  - NOTE at cycle 3;
  - `tone_out` shows the melody tone from cycle 4.
- `play_stop` at cycle 0 → IDLE at cycle 1; `tone_out` = 0 at cycle 2 unless a key is held.
- A key pressed at cycle k freezes the timer from cycle k+1. A key released at cycle r resumes counting from cycle r+1.
- `rom_addr` changes only on entry to FETCH. It is held stable through LOAD, NOTE and GAP.

## Test plan
All scenarios use `BEAT_DIV` = 10, `GAP_CYCLES` = 2, `SONG_LEN` = 4.
1. Reset and idle:
   - Stimulus: ROM {dur 1, tone 5}, {2, 8}, {0, x}; pulse `play_start`.
   - Required: `tone_out` = 5 for 8 cycles, 0 for 2 cycles, then 8 for 18 cycles, 0 for 2 cycles; then IDLE with `busy` = 0.
   - Also check reset values of all outputs.
2. Full ROM with no terminator, `loop_en` = 0:
   - Stimulus: 4 entries of dur 1.
   - Required: after address 3, state goes to IDLE and `rom_addr` returns to 0.
   - Repeat with `loop_en` = 1: the sequence repeats from address 0 after 2 fetch cycles.
3. Live override:
   - Stimulus: hold `keys`[2] and `keys`[7] for 5 cycles during a dur-1 note.
   - Required: `tone_out` = 3 while held; the note ends 5 cycles late; the total tone-5 cycles still equal 8.
4. Stop and start:
   - `play_start` and `play_stop` in the same cycle mid-note → IDLE, `tone_out` = 0.
   - Later, `play_start` mid-song → `rom_addr` = 0 on the next cycle.
5. Rest entry:
   - Stimulus: {dur 2, tone 0}.
   - Required: `tone_out` = 0 for all 20 cycles, `busy` = 1.
6. Asynchronous reset:
   - Stimulus: assert `rst_n` low mid-GAP with a key held, off a clock edge.
   - Required: all outputs reach their reset values immediately; IDLE after release.
